// File: rtl/dmem_access.sv
// Memory-stage data access unit: turns EX-stage load/store requests into word-wide bus
// cycles with byte enables, extracts load lanes, and reports misalignment and bus timeouts.
module dmem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  in_op,
  input  logic [1:0]  in_sz,
  input  logic        in_unsigned,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_reg_addr,
  output logic        stall_o,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_byte_en,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_wrdata,
  input  logic [31:0] bus_rddata,
  input  logic        bus_ack,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [4:0]  out_reg_addr,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_bus,
  output logic [31:0] bad_vaddr
);

  localparam logic [1:0] OP_D2R  = 2'd0;
  localparam logic [1:0] OP_M2R  = 2'd1;
  localparam logic [1:0] OP_R2M  = 2'd2;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;

  typedef enum logic {IDLE, BUS} state_t;

  state_t      state, state_next;
  logic [31:0] lat_addr;
  logic [1:0]  lat_sz;
  logic        lat_unsigned;
  logic        lat_is_load;
  logic [4:0]  lat_reg;
  logic [31:0] wait_cnt;

  logic        accept, is_load, is_store, misaligned, timeout_hit;
  logic [3:0]  req_be;
  logic [31:0] req_wrdata;
  logic [31:0] rd_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_value;

  // Upstream handshake: a request is taken on any edge where in_valid=1 and stall_o=0;
  // while stall_o=1 the upstream holds its request unchanged.
  assign stall_o = (state == BUS);

  always_comb begin
    accept      = (state == IDLE) && in_valid;
    is_load     = (in_op == OP_M2R);
    is_store    = (in_op == OP_R2M);
    misaligned  = 1'b0;
    req_be      = 4'b1111;
    req_wrdata  = in_data;
    case (in_sz)
      SZ_BYTE: begin
        req_be     = 4'b0001 << in_addr[1:0];
        req_wrdata = {4{in_data[7:0]}};
      end
      SZ_HALF: begin
        misaligned = in_addr[0];
        req_be     = in_addr[1] ? 4'b1100 : 4'b0011;
        req_wrdata = {2{in_data[15:0]}};
      end
      default: misaligned = |in_addr[1:0];
    endcase
    // Ack on the timeout edge wins, so the timeout only fires without ack.
    timeout_hit = (TIMEOUT_CYCLES != 0) && !bus_ack &&
                  ((wait_cnt + 32'd1) == TIMEOUT_CYCLES);
  end

  always_comb begin
    rd_shift = bus_rddata >> {lat_addr[1:0], 3'b000};
    ld_byte  = rd_shift[7:0];
    ld_half  = lat_addr[1] ? bus_rddata[31:16] : bus_rddata[15:0];
    case (lat_sz)
      SZ_BYTE: load_value = {{24{~lat_unsigned & ld_byte[7]}}, ld_byte};
      SZ_HALF: load_value = {{16{~lat_unsigned & ld_half[15]}}, ld_half};
      default: load_value = bus_rddata;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && (is_load || is_store) && !misaligned) state_next = BUS;
      BUS:  if (bus_ack || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      lat_addr     <= '0;
      lat_sz       <= '0;
      lat_unsigned <= 1'b0;
      lat_is_load  <= 1'b0;
      lat_reg      <= '0;
      wait_cnt     <= '0;
      bus_address  <= '0;
      bus_byte_en  <= '0;
      bus_read     <= 1'b0;
      bus_write    <= 1'b0;
      bus_wrdata   <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_reg_addr <= '0;
      exc_adel     <= 1'b0;
      exc_ades     <= 1'b0;
      exc_bus      <= 1'b0;
      bad_vaddr    <= '0;
    end else begin
      state        <= state_next;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_reg_addr <= '0;
      exc_adel     <= 1'b0;
      exc_ades     <= 1'b0;
      exc_bus      <= 1'b0;
      bad_vaddr    <= '0;
      case (state)
        IDLE: if (accept) begin
          lat_addr     <= in_addr;
          lat_sz       <= in_sz;
          lat_unsigned <= in_unsigned;
          lat_is_load  <= is_load;
          lat_reg      <= in_reg_addr;
          if (!is_load && !is_store) begin
            out_valid    <= 1'b1;
            out_data     <= in_data;
            out_reg_addr <= in_reg_addr;
          end else if (misaligned) begin
            out_valid <= 1'b1;
            exc_adel  <= is_load;
            exc_ades  <= is_store;
            bad_vaddr <= in_addr;
          end else begin
            bus_address <= {in_addr[31:2], 2'b00};
            bus_byte_en <= req_be;
            bus_read    <= is_load;
            bus_write   <= is_store;
            bus_wrdata  <= req_wrdata;
            wait_cnt    <= '0;
          end
        end
        BUS: begin
          if (bus_ack) begin
            bus_read     <= 1'b0;
            bus_write    <= 1'b0;
            bus_byte_en  <= '0;
            out_valid    <= 1'b1;
            out_data     <= lat_is_load ? load_value : 32'd0;
            out_reg_addr <= lat_is_load ? lat_reg : 5'd0;
          end else if (timeout_hit) begin
            bus_read    <= 1'b0;
            bus_write   <= 1'b0;
            bus_byte_en <= '0;
            out_valid   <= 1'b1;
            exc_bus     <= 1'b1;
            bad_vaddr   <= lat_addr;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Keeps the unused OP_D2R encoding documented next to its siblings.
  logic unused_ok;
  assign unused_ok = &{1'b0, OP_D2R};

endmodule

// File: tb/tb_dmem_access.sv
// Directed bench for dmem_access: expected writebacks go into a scoreboard queue and a
// negedge monitor checks every out_valid pulse; bus-side signals are checked inline.
module tb_dmem_access;

  localparam logic [1:0] OP_D2R = 2'd0, OP_M2R = 2'd1, OP_R2M = 2'd2;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;
  localparam int EXP_W = 72;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_op = '0;
  logic [1:0]  in_sz = '0;
  logic        in_unsigned = 1'b0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_reg_addr = '0;
  logic        stall_o;
  logic [31:0] bus_address;
  logic [3:0]  bus_byte_en;
  logic        bus_read, bus_write;
  logic [31:0] bus_wrdata;
  logic [31:0] bus_rddata = '0;
  logic        bus_ack = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_reg_addr;
  logic        exc_adel, exc_ades, exc_bus;
  logic [31:0] bad_vaddr;

  int compared = 0;
  int mismatched = 0;
  logic [EXP_W-1:0] exp_q[$];

  dmem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_op(in_op), .in_sz(in_sz),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_data(in_data),
    .in_reg_addr(in_reg_addr), .stall_o(stall_o), .bus_address(bus_address),
    .bus_byte_en(bus_byte_en), .bus_read(bus_read), .bus_write(bus_write),
    .bus_wrdata(bus_wrdata), .bus_rddata(bus_rddata), .bus_ack(bus_ack),
    .out_valid(out_valid), .out_data(out_data), .out_reg_addr(out_reg_addr),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus), .bad_vaddr(bad_vaddr)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [EXP_W-1:0] act,
                     input logic [EXP_W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] wb(input logic [31:0] d, input logic [4:0] r,
                                         input logic adel, input logic ades,
                                         input logic bexc, input logic [31:0] bad);
    return {d, r, adel, ades, bexc, bad};
  endfunction

  // Monitor: every writeback pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_out_valid: got data %h reg %0d with empty queue",
                 out_data, out_reg_addr);
      end else begin
        chk("writeback", {out_data, out_reg_addr, exc_adel, exc_ades, exc_bus, bad_vaddr},
            exp_q.pop_front());
      end
    end
  end

  // Drivers: request is presented for one edge, returns at the negedge after acceptance.
  task automatic send(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] data, input logic [4:0] r);
    @(negedge clk);
    in_op = op; in_sz = sz; in_unsigned = uns;
    in_addr = addr; in_data = data; in_reg_addr = r;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Holds ack low for 'waits' BUS edges, then acks; counts cycles seen with stall_o=1.
  task automatic bus_cycle(input int waits, input logic [31:0] rd, output int stalls);
    stalls = 0;
    for (int i = 0; i < waits; i++) begin
      if (stall_o) stalls++;
      @(negedge clk);
    end
    if (stall_o) stalls++;
    bus_ack = 1'b1;
    bus_rddata = rd;
    @(negedge clk);
    bus_ack = 1'b0;
    bus_rddata = '0;
  endtask

  task automatic chk_bus(input string name, input logic [31:0] addr, input logic [3:0] be,
                         input logic rd, input logic wr, input logic [31:0] wdata);
    chk(name, {bus_address, bus_byte_en, bus_read, bus_write, bus_wrdata},
        {addr, be, rd, wr, wdata});
  endtask

  task automatic chk_idle_bus(input string name);
    chk(name, {stall_o, bus_byte_en, bus_read, bus_write}, '0);
  endtask

  // Loads: issue, check strobe/byte_en, complete after 'waits' no-ack edges.
  task automatic do_load(input string name, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [4:0] r, input logic [3:0] be,
                         input int waits, input logic [31:0] rd, input logic [31:0] exp_d);
    int st;
    exp_q.push_back(wb(exp_d, r, 1'b0, 1'b0, 1'b0, 32'd0));
    send(OP_M2R, sz, uns, addr, 32'h0, r);
    chk_bus({name, "_bus"}, {addr[31:2], 2'b00}, be, 1'b1, 1'b0, 32'h0);
    bus_cycle(waits, rd, st);
    chk({name, "_stall_cycles"}, st, waits + 1);
    chk_idle_bus({name, "_after"});
  endtask

  task automatic do_store(input string name, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be,
                          input logic [31:0] wdata);
    int st;
    exp_q.push_back(wb(32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0));
    send(OP_R2M, sz, 1'b0, addr, data, 5'd9);
    chk_bus({name, "_bus"}, {addr[31:2], 2'b00}, be, 1'b0, 1'b1, wdata);
    bus_cycle(0, 32'h0, st);
    chk_idle_bus({name, "_after"});
  endtask

  initial begin
    int st;
    repeat (3) @(negedge clk);
    chk("reset_bus", {stall_o, bus_address, bus_byte_en, bus_read, bus_write, bus_wrdata}, '0);
    chk("reset_out", {out_valid, out_data, out_reg_addr, exc_adel, exc_ades, exc_bus,
                      bad_vaddr}, '0);
    rst_n = 1'b1;

    // Register pass-through
    exp_q.push_back(wb(32'hDEADBEEF, 5'd5, 1'b0, 1'b0, 1'b0, 32'd0));
    send(OP_D2R, SZ_W, 1'b0, 32'h0, 32'hDEADBEEF, 5'd5);
    chk_idle_bus("d2r_no_bus");

    // Loads across sizes, lanes and extension modes
    do_load("lb_signed", SZ_B, 1'b0, 32'h1003, 5'd7, 4'b1000, 3, 32'h80AABBCC, 32'hFFFFFF80);
    do_load("lhu_upper", SZ_H, 1'b1, 32'h4002, 5'd8, 4'b1100, 1, 32'h80017FFF, 32'h00008001);
    do_load("lh_lower", SZ_H, 1'b0, 32'h4000, 5'd10, 4'b0011, 0, 32'h12348001, 32'hFFFF8001);
    do_load("lbu_lane1", SZ_B, 1'b1, 32'h5001, 5'd11, 4'b0010, 2, 32'h0000F200, 32'h000000F2);
    // Ack lands on the same edge the timeout would fire: normal completion
    do_load("lw_ack_at_limit", SZ_W, 1'b0, 32'h9000, 5'd3, 4'b1111, 3, 32'h11223344,
            32'h11223344);

    // Stores
    do_store("sh_upper", SZ_H, 32'h2002, 32'h00001234, 4'b1100, 32'h12341234);
    do_store("sb_lane3", SZ_B, 32'h6003, 32'h000000AB, 4'b1000, 32'hABABABAB);
    do_store("sw", SZ_W, 32'h7000, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

    // Misaligned accesses never reach the bus
    exp_q.push_back(wb(32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h3001));
    send(OP_M2R, SZ_W, 1'b0, 32'h3001, 32'h0, 5'd6);
    chk_idle_bus("lw_misaligned_bus");
    @(negedge clk);
    chk_idle_bus("lw_misaligned_bus_later");
    exp_q.push_back(wb(32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h00000011));
    send(OP_R2M, SZ_H, 1'b0, 32'h00000011, 32'h5555, 5'd4);
    chk_idle_bus("sh_misaligned_bus");

    // Timeout: no ack for 4 BUS cycles
    exp_q.push_back(wb(32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h8000));
    send(OP_M2R, SZ_W, 1'b0, 32'h8000, 32'h0, 5'd12);
    st = 0;
    for (int i = 0; i < 12 && stall_o; i++) begin
      st++;
      @(negedge clk);
    end
    chk("timeout_stall_cycles", st, 4);
    chk_idle_bus("timeout_after");

    // Ack while idle must be ignored
    bus_ack = 1'b1;
    bus_rddata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    bus_ack = 1'b0;
    chk_idle_bus("idle_ack_ignored");

    // Reset in the middle of a bus cycle abandons it
    send(OP_M2R, SZ_W, 1'b0, 32'hA000, 32'h0, 5'd13);
    chk_bus("abort_bus_started", 32'hA000, 4'b1111, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_strobes", {stall_o, bus_byte_en, bus_read, bus_write, out_valid}, '0);
    rst_n = 1'b1;
    exp_q.push_back(wb(32'h00000055, 5'd1, 1'b0, 1'b0, 1'b0, 32'd0));
    send(OP_D2R, SZ_W, 1'b0, 32'h0, 32'h00000055, 5'd1);

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
